// File: rtl/mem_arbiter.sv
// mem_arbiter: round-robin arbiter sharing a single 16-bit DMA window port
// (dmemreq/dmemack) between NREQ level-handshake requesters. Holds at most one
// downstream transaction; a missing downstream answer yields a bus-error ack.
module mem_arbiter #(
    parameter int NREQ    = 4,
    parameter int TIMEOUT = 1024,
    parameter int TW      = 10
) (
    input  logic               clk,
    input  logic               resetn,
    input  logic [NREQ-1:0]    ureq,
    input  logic [NREQ-1:0]    uwr,
    input  logic [NREQ*22-1:0] uaddr,
    input  logic [NREQ*16-1:0] uwdata,
    input  logic [NREQ*2-1:0]  uwstrb,
    output logic [NREQ-1:0]    uack,
    output logic               uerr,
    output logic [15:0]        urdata,
    output logic               dmemreq,
    output logic               dmemwr,
    output logic [21:0]        dmemaddr,
    output logic [15:0]        dmemwdata,
    output logic [1:0]         dmemwstrb,
    input  logic               dmemack,
    input  logic [15:0]        dmemrdata
);

    localparam int AW = 22;
    localparam int DW = 16;
    localparam int SW = 2;
    localparam int PW = $clog2(NREQ);

    localparam logic [TW-1:0]   CNT_LIM  = TW'(TIMEOUT - 1);
    localparam logic [PW-1:0]   LAST_REQ = PW'(NREQ - 1);
    localparam logic [NREQ-1:0] ONE_HOT0 = NREQ'(1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t            state_r, state_nx;
    logic [PW-1:0]     rr_r, rr_nx;
    logic [PW-1:0]     gnt_r, gnt_nx;
    logic [TW-1:0]     cnt_r, cnt_nx;
    logic              dmemreq_r, dmemreq_nx;
    logic              dmemwr_r, dmemwr_nx;
    logic [AW-1:0]     dmemaddr_r, dmemaddr_nx;
    logic [DW-1:0]     dmemwdata_r, dmemwdata_nx;
    logic [SW-1:0]     dmemwstrb_r, dmemwstrb_nx;
    logic [NREQ-1:0]   uack_r, uack_nx;
    logic              uerr_r, uerr_nx;
    logic [DW-1:0]     urdata_r, urdata_nx;
    logic [PW-1:0]     gsel_s;

    // Round-robin pick: lowest offset above the rr pointer (mod NREQ) with ureq set wins
    always_comb begin
        int idx;
        idx    = 0;
        gsel_s = {PW{1'b0}};
        for (int i = NREQ - 1; i >= 0; i--) begin
            idx    = (int'(rr_r) + i) % NREQ;
            gsel_s = ureq[idx] ? PW'(idx) : gsel_s;
        end
    end

    // Next-state and next-register values for the IDLE/WAIT/DONE handshake
    always_comb begin
        state_nx     = state_r;
        rr_nx        = rr_r;
        gnt_nx       = gnt_r;
        cnt_nx       = cnt_r;
        dmemreq_nx   = 1'b0;
        dmemwr_nx    = dmemwr_r;
        dmemaddr_nx  = dmemaddr_r;
        dmemwdata_nx = dmemwdata_r;
        dmemwstrb_nx = dmemwstrb_r;
        uack_nx      = {NREQ{1'b0}};
        uerr_nx      = 1'b0;
        urdata_nx    = urdata_r;
        case (state_r)
            ST_IDLE: begin
                if (|ureq) begin
                    gnt_nx       = gsel_s;
                    dmemwr_nx    = uwr[gsel_s];
                    dmemaddr_nx  = uaddr[int'(gsel_s) * AW +: AW];
                    dmemwdata_nx = uwdata[int'(gsel_s) * DW +: DW];
                    dmemwstrb_nx = uwstrb[int'(gsel_s) * SW +: SW];
                    dmemreq_nx   = 1'b1;
                    cnt_nx       = {TW{1'b0}};
                    state_nx     = ST_WAIT;
                end else begin
                    state_nx = ST_IDLE;
                end
            end
            ST_WAIT: begin
                // A real ack beats a timeout landing on the same edge
                if (dmemack) begin
                    uack_nx   = ONE_HOT0 << gnt_r;
                    uerr_nx   = 1'b0;
                    urdata_nx = dmemrdata;
                    state_nx  = ST_DONE;
                end else if (cnt_r == CNT_LIM) begin
                    uack_nx   = ONE_HOT0 << gnt_r;
                    uerr_nx   = 1'b1;
                    urdata_nx = 16'h0000;
                    state_nx  = ST_DONE;
                end else begin
                    cnt_nx = cnt_r + TW'(1);
                end
            end
            ST_DONE: begin
                // ureq ignored here so the requester has a cycle to drop it
                rr_nx    = (gnt_r == LAST_REQ) ? {PW{1'b0}} : gnt_r + PW'(1);
                state_nx = ST_IDLE;
            end
            default: begin
                state_nx = ST_IDLE;
            end
        endcase
    end

    // FSM state register
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nx;
        end
    end

    // Datapath, pointer, counter and output registers
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            rr_r        <= {PW{1'b0}};
            gnt_r       <= {PW{1'b0}};
            cnt_r       <= {TW{1'b0}};
            dmemreq_r   <= 1'b0;
            dmemwr_r    <= 1'b0;
            dmemaddr_r  <= {AW{1'b0}};
            dmemwdata_r <= {DW{1'b0}};
            dmemwstrb_r <= {SW{1'b0}};
            uack_r      <= {NREQ{1'b0}};
            uerr_r      <= 1'b0;
            urdata_r    <= {DW{1'b0}};
        end else begin
            rr_r        <= rr_nx;
            gnt_r       <= gnt_nx;
            cnt_r       <= cnt_nx;
            dmemreq_r   <= dmemreq_nx;
            dmemwr_r    <= dmemwr_nx;
            dmemaddr_r  <= dmemaddr_nx;
            dmemwdata_r <= dmemwdata_nx;
            dmemwstrb_r <= dmemwstrb_nx;
            uack_r      <= uack_nx;
            uerr_r      <= uerr_nx;
            urdata_r    <= urdata_nx;
        end
    end

    assign uack      = uack_r;
    assign uerr      = uerr_r;
    assign urdata    = urdata_r;
    assign dmemreq   = dmemreq_r;
    assign dmemwr    = dmemwr_r;
    assign dmemaddr  = dmemaddr_r;
    assign dmemwdata = dmemwdata_r;
    assign dmemwstrb = dmemwstrb_r;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed self-checking bench for mem_arbiter (NREQ=4, TIMEOUT=8).
module tb_mem_arbiter;

    localparam int NREQ = 4;

    logic               clk;
    logic               resetn;
    logic [NREQ-1:0]    ureq;
    logic [NREQ-1:0]    uwr;
    logic [NREQ*22-1:0] uaddr;
    logic [NREQ*16-1:0] uwdata;
    logic [NREQ*2-1:0]  uwstrb;
    logic [NREQ-1:0]    uack;
    logic               uerr;
    logic [15:0]        urdata;
    logic               dmemreq;
    logic               dmemwr;
    logic [21:0]        dmemaddr;
    logic [15:0]        dmemwdata;
    logic [1:0]         dmemwstrb;
    logic               dmemack;
    logic [15:0]        dmemrdata;

    int pass_cnt;
    int check_cnt;

    mem_arbiter #(.NREQ(NREQ), .TIMEOUT(8), .TW(3)) dut (
        .clk(clk), .resetn(resetn),
        .ureq(ureq), .uwr(uwr), .uaddr(uaddr), .uwdata(uwdata), .uwstrb(uwstrb),
        .uack(uack), .uerr(uerr), .urdata(urdata),
        .dmemreq(dmemreq), .dmemwr(dmemwr), .dmemaddr(dmemaddr),
        .dmemwdata(dmemwdata), .dmemwstrb(dmemwstrb),
        .dmemack(dmemack), .dmemrdata(dmemrdata)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // advance to 1 time unit after the next rising edge
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [21:0] addr_of(input int i);
        return 22'h000040 * (i + 1);
    endfunction

    task automatic test_reset();
        resetn = 1'b0; ureq = '0; uwr = '0; uaddr = '0; uwdata = '0; uwstrb = '0;
        dmemack = 1'b0; dmemrdata = 16'h0000;
        tick(); tick();
        check_cnt++;
        if ({dmemreq, uack, uerr, urdata} !== 22'h0) begin
            $display("FAIL reset_out got req=%b ack=%b err=%b rdata=%h want 0", dmemreq, uack, uerr, urdata);
        end else pass_cnt++;
        check_cnt++;
        if ({dmemwr, dmemaddr, dmemwdata, dmemwstrb} !== 41'h0) begin
            $display("FAIL reset_dmem got wr=%b addr=%h wd=%h st=%b want 0", dmemwr, dmemaddr, dmemwdata, dmemwstrb);
        end else pass_cnt++;
        resetn = 1'b1;
        tick();
    endtask

    task automatic test_single_read();
        uaddr[21:0] = 22'h000100; uwr[0] = 1'b0; ureq = 4'b0001;
        tick();
        check_cnt++;
        if ({dmemreq, dmemwr, dmemaddr} !== {1'b1, 1'b0, 22'h000100}) begin
            $display("FAIL read_req got req=%b wr=%b addr=%h want 1 0 000100", dmemreq, dmemwr, dmemaddr);
        end else pass_cnt++;
        tick();
        check_cnt++;
        if (dmemreq !== 1'b0) begin
            $display("FAIL read_pulse_width got dmemreq=%b want 0", dmemreq);
        end else pass_cnt++;
        tick();
        dmemack = 1'b1; dmemrdata = 16'hBEEF;
        check_cnt++;
        if (uack !== 4'b0000) begin
            $display("FAIL read_early_ack got uack=%b want 0000", uack);
        end else pass_cnt++;
        tick();
        dmemack = 1'b0; ureq = 4'b0000;
        check_cnt++;
        if ({uack, uerr, urdata} !== {4'b0001, 1'b0, 16'hBEEF}) begin
            $display("FAIL read_ack got uack=%b err=%b rdata=%h want 0001 0 beef", uack, uerr, urdata);
        end else pass_cnt++;
        tick();
        check_cnt++;
        if (uack !== 4'b0000) begin
            $display("FAIL read_ack_width got uack=%b want 0000", uack);
        end else pass_cnt++;
    endtask

    task automatic test_write();
        uwr[2] = 1'b1; uaddr[44 +: 22] = 22'h3FFFFE; uwdata[32 +: 16] = 16'h1234; uwstrb[4 +: 2] = 2'b10;
        ureq = 4'b0100;
        tick();
        dmemack = 1'b1; dmemrdata = 16'h0000;
        check_cnt++;
        if ({dmemreq, dmemwr, dmemaddr, dmemwdata, dmemwstrb} !== {1'b1, 1'b1, 22'h3FFFFE, 16'h1234, 2'b10}) begin
            $display("FAIL write_fields got req=%b wr=%b addr=%h wd=%h st=%b want 1 1 3ffffe 1234 10",
                     dmemreq, dmemwr, dmemaddr, dmemwdata, dmemwstrb);
        end else pass_cnt++;
        tick();
        dmemack = 1'b0; ureq = 4'b0000;
        check_cnt++;
        if ({uack, uerr} !== {4'b0100, 1'b0}) begin
            $display("FAIL write_ack got uack=%b err=%b want 0100 0", uack, uerr);
        end else pass_cnt++;
        tick();
        uwr = '0;
    endtask

    // one full transaction with an immediate ack; ureq bits must already be set
    task automatic rr_step(input int exp_g);
        tick();
        dmemack = 1'b1; dmemrdata = 16'hA5A5;
        check_cnt++;
        if ({dmemreq, dmemaddr} !== {1'b1, addr_of(exp_g)}) begin
            $display("FAIL rr_addr got req=%b addr=%h want 1 %h", dmemreq, dmemaddr, addr_of(exp_g));
        end else pass_cnt++;
        tick();
        dmemack = 1'b0;
        check_cnt++;
        if (uack !== 4'(1 << exp_g)) begin
            $display("FAIL rr_grant got uack=%b want %b", uack, 4'(1 << exp_g));
        end else pass_cnt++;
        ureq[exp_g] = 1'b0;
        tick();
    endtask

    task automatic test_round_robin();
        resetn = 1'b0; tick(); resetn = 1'b1;
        for (int i = 0; i < NREQ; i++) uaddr[i*22 +: 22] = addr_of(i);
        ureq = 4'b1111;
        for (int k = 0; k < NREQ; k++) rr_step(k);
        ureq = 4'b0010;
        rr_step(1);
        ureq = 4'b0011;
        rr_step(0);
        rr_step(1);
    endtask

    task automatic test_timeout();
        ureq = 4'b0001;
        tick();
        for (int j = 0; j < 7; j++) begin
            tick();
            check_cnt++;
            if (uack !== 4'b0000) begin
                $display("FAIL timeout_early cycle %0d got uack=%b want 0000", j, uack);
            end else pass_cnt++;
        end
        tick();
        ureq = 4'b0000;
        check_cnt++;
        if ({uack, uerr, urdata} !== {4'b0001, 1'b1, 16'h0000}) begin
            $display("FAIL timeout_ack got uack=%b err=%b rdata=%h want 0001 1 0000", uack, uerr, urdata);
        end else pass_cnt++;
        tick(); tick();
        dmemack = 1'b1; dmemrdata = 16'h7777;
        tick();
        dmemack = 1'b0;
        tick();
        check_cnt++;
        if ({uack, urdata, dmemreq} !== {4'b0000, 16'h0000, 1'b0}) begin
            $display("FAIL stale_ack got uack=%b rdata=%h req=%b want 0000 0000 0", uack, urdata, dmemreq);
        end else pass_cnt++;
    endtask

    task automatic test_race();
        ureq = 4'b0010;
        tick();
        for (int j = 0; j < 7; j++) tick();
        dmemack = 1'b1; dmemrdata = 16'hC0DE;
        tick();
        dmemack = 1'b0; ureq = 4'b0000;
        check_cnt++;
        if ({uack, uerr, urdata} !== {4'b0010, 1'b0, 16'hC0DE}) begin
            $display("FAIL race_ack got uack=%b err=%b rdata=%h want 0010 0 c0de", uack, uerr, urdata);
        end else pass_cnt++;
        tick();
    endtask

    task automatic test_async_reset();
        ureq = 4'b0100;
        tick();
        tick();
        #2;
        resetn = 1'b0;
        #1;
        check_cnt++;
        if ({dmemreq, uack, uerr, urdata, dmemwr, dmemaddr, dmemwdata, dmemwstrb} !== 63'h0) begin
            $display("FAIL async_reset got req=%b ack=%b err=%b rdata=%h addr=%h want 0",
                     dmemreq, uack, uerr, urdata, dmemaddr);
        end else pass_cnt++;
        ureq = 4'b0000;
        tick();
        resetn = 1'b1;
        dmemack = 1'b1; dmemrdata = 16'h5555;
        tick();
        dmemack = 1'b0;
        tick();
        check_cnt++;
        if ({uack, urdata} !== {4'b0000, 16'h0000}) begin
            $display("FAIL stray_ack_idle got uack=%b rdata=%h want 0000 0000", uack, urdata);
        end else pass_cnt++;
        ureq = 4'b1000;
        rr_step(3);
    endtask

    initial begin
        pass_cnt  = 0;
        check_cnt = 0;
        test_reset();
        test_single_read();
        test_write();
        test_round_robin();
        test_timeout();
        test_race();
        test_async_reset();
        $display("%0d/%0d checks passed", pass_cnt, check_cnt);
        $finish;
    end

endmodule
